mem_responder: RTL and testbench

- Memory-side responder for the picorv32-style native memory interface driven by our RV32I core. It answers instruction fetches, loads and stores against an on-chip word array, with a configurable wait-state latency.
- A side load port lets the testbench or boot logic preload program images while the bus is idle.
- It sits between the core and the SoC's local RAM and flags out-of-range accesses.

---
 rtl/mem_responder_pkg.sv | 6 +
 rtl/mem_responder_array.sv | 20 ++
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;
  localparam logic [31:0] FAULT_RDATA = 32'hDEAD_BEEF;
  localparam int LAT_W = 4;
endpackage

// File: rtl/mem_responder_array.sv
// DEPTH_WORDS x 32 word array: synchronous byte-enabled write, combinational read.
module mem_responder_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// picorv32-style memory responder with wait states and a side preload port.
// Optional macro MEM_RESPONDER_STATS_EN adds fetch/read/write completion counters.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        fault,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] stat_fetches,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  state_t           state, state_nx;
  logic [LAT_W-1:0] cnt, cnt_nx;
  logic [31:0]      cap_addr, cap_wdata;
  logic [3:0]       cap_wstrb;
  logic             accept, enter_resp, load_fire, req_ok;
  logic [31:0]      req_addr, req_wdata;
  logic [3:0]       req_wstrb;
  logic             arr_we;
  logic [3:0]       arr_be;
  logic [AW-1:0]    arr_addr;
  logic [31:0]      arr_wdata, arr_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (mem_valid) begin
        cnt_nx   = LAT_W'(LATENCY - 1);
        state_nx = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_nx = cnt - LAT_W'(1);
        if (cnt == LAT_W'(1)) state_nx = RESP;
      end
      RESP: state_nx = DONE;
      DONE: if (!mem_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && mem_valid;
  assign enter_resp = (state_nx == RESP);
  assign mem_ready  = (state == RESP);
  assign load_ready = (state == IDLE) && !mem_valid;
  assign load_fire  = load_valid && load_ready;

  // With LATENCY=1 the response is formed on the accepting edge, so use the live bus in IDLE.
  assign req_addr  = (state == IDLE) ? mem_addr  : cap_addr;
  assign req_wdata = (state == IDLE) ? mem_wdata : cap_wdata;
  assign req_wstrb = (state == IDLE) ? mem_wstrb : cap_wstrb;
  assign req_ok    = in_range(req_addr);

  // Preload and core commit are mutually exclusive: preload needs IDLE with mem_valid low.
  assign arr_addr  = load_fire ? widx(load_addr) : widx(req_addr);
  assign arr_we    = load_fire ? in_range(load_addr) : (enter_resp && req_ok);
  assign arr_be    = load_fire ? 4'hF : req_wstrb;
  assign arr_wdata = load_fire ? load_data : req_wdata;

  mem_responder_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= '0;
      fault     <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
    end else begin
      fault <= 1'b0;
      if (accept) begin
        cap_addr  <= mem_addr;
        cap_wdata <= mem_wdata;
        cap_wstrb <= mem_wstrb;
      end
      if (enter_resp) begin
        mem_rdata <= req_ok ? arr_rdata : FAULT_RDATA;
        fault     <= !req_ok;
      end
      if (load_fire && !in_range(load_addr)) fault <= 1'b1;
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  logic cap_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_instr    <= 1'b0;
      stat_fetches <= '0;
      stat_reads   <= '0;
      stat_writes  <= '0;
    end else begin
      if (accept) cap_instr <= mem_instr;
      // fault is registered alongside the RESP entry, so it marks a faulting response here
      if (state == RESP && !fault) begin
        if (cap_instr) begin
          if (stat_fetches != '1) stat_fetches <= stat_fetches + 32'd1;
        end else if (cap_wstrb == 4'h0) begin
          if (stat_reads != '1) stat_reads <= stat_reads + 32'd1;
        end else begin
          if (stat_writes != '1) stat_writes <= stat_writes + 32'd1;
        end
      end
    end
  end
`else
  logic unused_instr;
  assign unused_instr = mem_instr;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: dut 0 runs LATENCY=1, dut 1 runs LATENCY=3, both 1024 words at base 0.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        mv [2], mi [2], lv [2];
  logic [31:0] ma [2], mw [2], la [2], ld [2];
  logic [3:0]  ms [2];
  logic        mr [2], flt [2], lr [2];
  logic [31:0] mrd [2];

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(rst), .mem_valid(mv[0]), .mem_instr(mi[0]), .mem_ready(mr[0]),
    .mem_addr(ma[0]), .mem_wdata(mw[0]), .mem_wstrb(ms[0]), .mem_rdata(mrd[0]),
    .fault(flt[0]), .load_valid(lv[0]), .load_ready(lr[0]), .load_addr(la[0]),
    .load_data(ld[0])
  );

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset(rst), .mem_valid(mv[1]), .mem_instr(mi[1]), .mem_ready(mr[1]),
    .mem_addr(ma[1]), .mem_wdata(mw[1]), .mem_wstrb(ms[1]), .mem_rdata(mrd[1]),
    .fault(flt[1]), .load_valid(lv[1]), .load_ready(lr[1]), .load_addr(la[1]),
    .load_data(ld[1])
  );

  task automatic preload(input int d, input logic [31:0] addr, input logic [31:0] data,
                         input logic exp_fault, input string name);
    int n;
    @(posedge clk); #1;
    lv[d] = 1'b1; la[d] = addr; ld[d] = data;
    n = 0;
    do begin @(negedge clk); n++; end while (!lr[d] && n < 20);
    checks++;
    if (lr[d] !== 1'b1) $display("FAIL %s load_ready: got %b expected 1", name, lr[d]);
    else passed++;
    @(posedge clk); #1;
    lv[d] = 1'b0;
    @(negedge clk);
    checks++;
    if (flt[d] !== exp_fault) $display("FAIL %s fault: got %b expected %b", name, flt[d], exp_fault);
    else passed++;
  endtask

  task automatic core_req(input int d, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, input logic instr, input logic [31:0] exp_rdata,
                          input logic exp_fault, input int hold, input string name);
    int lat;
    exp_t e;
    @(posedge clk); #1;
    mv[d] = 1'b1; ma[d] = addr; ms[d] = strb; mw[d] = wdata; mi[d] = instr;
    sb.push_back('{exp_rdata, exp_fault, (d == 0) ? 1 : 3});
    lat = 0;
    do begin
      @(posedge clk); #1;
      ma[d] = ~addr; mw[d] = ~wdata; ms[d] = ~strb;
      @(negedge clk);
      lat++;
    end while (!mr[d] && lat < 20);
    e = sb.pop_front();
    checks++;
    if (mr[d] !== 1'b1) $display("FAIL %s ready timeout: got %b expected 1", name, mr[d]);
    else passed++;
    checks++;
    if (lat != e.lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
    else passed++;
    checks++;
    if (mrd[d] !== e.rdata) $display("FAIL %s rdata: got %h expected %h", name, mrd[d], e.rdata);
    else passed++;
    checks++;
    if (flt[d] !== e.fault) $display("FAIL %s fault: got %b expected %b", name, flt[d], e.fault);
    else passed++;
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk); #1;
      if (i == hold) mv[d] = 1'b0;
      @(negedge clk);
      checks++;
      if (mr[d] !== 1'b0) $display("FAIL %s extra ready: got %b expected 0", name, mr[d]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mr[d] !== 1'b0) $display("FAIL reset mem_ready[%0d]: got %b expected 0", d, mr[d]);
      else passed++;
      checks++;
      if (mrd[d] !== 32'h0) $display("FAIL reset mem_rdata[%0d]: got %h expected 0", d, mrd[d]);
      else passed++;
      checks++;
      if (flt[d] !== 1'b0) $display("FAIL reset fault[%0d]: got %b expected 0", d, flt[d]);
      else passed++;
      checks++;
      if (lr[d] !== 1'b1) $display("FAIL reset load_ready[%0d]: got %b expected 1", d, lr[d]);
      else passed++;
    end
  endtask

  task automatic test_fetch();
    preload(0, 32'h0, 32'h0000_0013, 1'b0, "fetch_pre");
    core_req(0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0000_0013, 1'b0, 0, "fetch");
  endtask

  task automatic test_latency();
    preload(1, 32'h40, 32'h1234_5678, 1'b0, "lat_pre");
    core_req(1, 32'h40, 4'h0, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 5, "lat3_hold");
  endtask

  task automatic test_store();
    preload(0, 32'h4, 32'hAABB_CCDD, 1'b0, "st_pre");
    core_req(0, 32'h4, 4'b0001, 32'h0000_00EE, 1'b0, 32'hAABB_CCDD, 1'b0, 0, "st_wr");
    core_req(0, 32'h4, 4'h0, 32'h0, 1'b0, 32'hAABB_CCEE, 1'b0, 0, "st_rd");
  endtask

  task automatic test_back_to_back();
    core_req(1, 32'h40, 4'b1100, 32'hA5A5_0000, 1'b0, 32'h1234_5678, 1'b0, 0, "b2b_wr");
    core_req(1, 32'h40, 4'h0, 32'h0, 1'b0, 32'hA5A5_5678, 1'b0, 0, "b2b_rd");
  endtask

  task automatic test_fault();
    core_req(0, 32'h1000, 4'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 0, "oor_rd");
    core_req(0, 32'h1000, 4'hF, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, 1'b1, 0, "oor_wr");
    core_req(0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0000_0013, 1'b0, 0, "oor_w0");
    preload(0, 32'h1000, 32'h5555_5555, 1'b1, "oor_pre");
    core_req(0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0000_0013, 1'b0, 0, "oor_pre_w0");
    preload(0, 32'hFFC, 32'hCAFE_F00D, 1'b0, "last_pre");
    core_req(0, 32'hFFC, 4'h0, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 0, "last_rd");
  endtask

  task automatic test_conflict();
    @(posedge clk); #1;
    lv[0] = 1'b1; la[0] = 32'h10; ld[0] = 32'h600D_D00D;
    mv[0] = 1'b1; ma[0] = 32'h0; ms[0] = 4'h0; mw[0] = 32'h0; mi[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (lr[0] !== 1'b0) $display("FAIL conf lr_same: got %b expected 0", lr[0]);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mr[0] !== 1'b1 || mrd[0] !== 32'h0000_0013)
      $display("FAIL conf core: got ready %b rdata %h expected 1 00000013", mr[0], mrd[0]);
    else passed++;
    @(posedge clk); #1;
    mv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (lr[0] !== 1'b0) $display("FAIL conf lr_done: got %b expected 0", lr[0]);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (lr[0] !== 1'b1) $display("FAIL conf lr_idle: got %b expected 1", lr[0]);
    else passed++;
    @(posedge clk); #1;
    lv[0] = 1'b0;
    core_req(0, 32'h10, 4'h0, 32'h0, 1'b0, 32'h600D_D00D, 1'b0, 0, "conf_rd");
  endtask

  task automatic test_reset_mid();
    preload(1, 32'h8, 32'h0, 1'b0, "rst_pre");
    @(posedge clk); #1;
    mv[1] = 1'b1; ma[1] = 32'h8; ms[1] = 4'hF; mw[1] = 32'hFFFF_FFFF; mi[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mv[1] = 1'b0;
    #1;
    checks++;
    if (mr[1] !== 1'b0) $display("FAIL rst_mid ready: got %b expected 0", mr[1]);
    else passed++;
    @(negedge clk);
    checks++;
    if (mr[1] !== 1'b0) $display("FAIL rst_mid ready2: got %b expected 0", mr[1]);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    core_req(1, 32'h8, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0, "rst_rd");
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; mi[d] = 1'b0; lv[d] = 1'b0;
      ma[d] = '0; mw[d] = '0; ms[d] = '0; la[d] = '0; ld[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_latency();
    test_store();
    test_back_to_back();
    test_fault();
    test_conflict();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
